chan_mux_scan: RTL
==================

CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Interface
- REQ-001 Parameter N_CH, default 8: number of input channels, 2..64.
- REQ-002 Parameter W, default 1: width of each channel in bits, 1..32.
- REQ-003 Parameter DWELL, default 4: cycles spent on each channel in scan mode, 1..255.
- REQ-004 Localparam SEL_W = clog2(N_CH), minimum 1.
- REQ-005 clk  input  1  single clock; all state updates on the rising edge.
- REQ-006 rst_n  input  1  asynchronous, active-low reset.
- REQ-007 din  input  N_CH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
- REQ-008 sel  input  SEL_W  channel select in manual mode.
- REQ-009 mode  input  1  0 = manual, 1 = scan.
- REQ-010 start  input  1  single-cycle request to begin one scan sweep.
- REQ-011 en_mask  input  N_CH  per-channel enable; used only when MUX_SKIP_MASK_EN is defined.
- REQ-012 dout  output  W  registered selected channel data.
- REQ-013 dout_valid  output  1  dout qualifier.
- REQ-014 cur_ch  output  SEL_W  channel index currently driving dout.
- REQ-015 busy  output  1  high while a scan sweep is in progress.

Function
- REQ-016 The FSM SHALL have two states: IDLE and SCAN.
- REQ-017 Manual mode, IDLE: dout SHALL equal din channel sel one cycle after sel is sampled. cur_ch SHALL equal the registered sel. dout_valid SHALL be 1.
- REQ-018 Manual mode, sel >= N_CH: the following cycle SHALL give dout = 0, dout_valid = 0, and cur_ch = the registered sel.
- REQ-019 IDLE with start=1 and mode=1: the FSM SHALL go to SCAN on the next edge, with channel counter = first channel, dwell counter = 0, and busy = 1.
- REQ-020 SCAN: each cycle, dout SHALL take din of the current channel (1-cycle latency) and cur_ch SHALL take the current channel.
- REQ-021 SCAN: the dwell counter SHALL count 0..DWELL-1.
- REQ-022 SCAN: dout_valid SHALL be 1 only in the cycle in which dout holds the sample taken at dwell count DWELL-1; otherwise 0.
- REQ-023 SCAN, dwell count DWELL-1 on a channel that is not the last: the FSM SHALL advance to the next channel and reset the dwell counter to 0.
- REQ-024 SCAN, dwell count DWELL-1 on the last channel: the FSM SHALL return to IDLE, with busy = 0 from the next cycle. Exactly one sweep occurs per start.
- REQ-025 start SHALL be ignored while busy=1. start with mode=0 SHALL be ignored.
- REQ-026 mode falling to 0 during SCAN SHALL abort the sweep: IDLE on the next edge, busy = 0, no dout_valid pulse for the partial dwell.
- REQ-027 start and a sweep completion in the same cycle SHALL NOT restart the sweep; a new start is required after busy = 0.
- REQ-028 DWELL=1 SHALL give one cycle per channel with dout_valid high on every SCAN output cycle.

Reset
- REQ-029 rst_n=0 SHALL immediately force: state IDLE, dout = 0, dout_valid = 0, cur_ch = 0, busy = 0, both counters = 0.
- REQ-030 Reset asserted mid-sweep SHALL discard the sweep. After release, operation SHALL resume from IDLE with no dout_valid pulse until it is legitimately produced.

Configuration
- REQ-031 Macro MUX_SKIP_MASK_EN defined: scan SHALL visit only channels with en_mask[k]=1, in ascending order. The first channel is the lowest enabled index and the last channel is the highest enabled index. en_mask SHALL be sampled at start and held for the sweep. start with en_mask = 0 SHALL be ignored.
- REQ-032 Macro MUX_SKIP_MASK_EN undefined: en_mask SHALL be ignored, and scan SHALL visit channels 0..N_CH-1 in order.

Verification
- REQ-033 Defaults (N_CH=8, W=1, DWELL=4): manual mode, din=8'hA5, sel stepped 0..7 -> dout = 1,0,1,0,0,1,0,1, each one cycle after its sel, with dout_valid=1.
- REQ-034 N_CH=6, W=8: manual mode with sel=7 -> dout=8'h00 and dout_valid=0 the next cycle; sel=5 -> dout = channel 5 data.
- REQ-035 Defaults: start pulse in scan mode -> busy high for 32 cycles, 8 dout_valid pulses spaced 4 cycles apart with cur_ch = 0..7, then busy=0.
- REQ-036 Mid-sweep abort: mode dropped to 0 at channel 3 -> busy=0 next cycle, no further valid pulses from the sweep. Separately, rst_n pulsed low at channel 5 -> all outputs 0 immediately.
- REQ-037 With MUX_SKIP_MASK_EN defined, en_mask=8'b0100_1010 -> valid pulses only for cur_ch = 1, 3, 6, and busy high for 12 cycles. With en_mask=0, start is ignored and busy stays 0.

Source files
------------

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: N_CH-channel registered mux with a manual select mode and
// a one-shot scan mode that dwells DWELL cycles on each channel.
// Optional feature: define MUX_SKIP_MASK_EN to restrict scan sweeps to the
// channels enabled in en_mask (sampled at start).
module chan_mux_scan #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 4,
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH*W-1:0]   din,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic                start,
    input  logic [N_CH-1:0]     en_mask,
    output logic [W-1:0]        dout,
    output logic                dout_valid,
    output logic [SEL_W-1:0]    cur_ch,
    output logic                busy
);

    localparam int unsigned DW_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  ch_q;
    logic [DW_W-1:0]   dwell_q;
    logic [W-1:0]      dout_q;
    logic              valid_q;
    logic [SEL_W-1:0]  cur_ch_q;
    logic              busy_q;

    logic [N_CH-1:0]   scan_mask_c;
    logic [N_CH-1:0]   first_mask_c;
    logic              start_ok_c;

`ifdef MUX_SKIP_MASK_EN
    logic [N_CH-1:0]   mask_q;

    assign scan_mask_c  = mask_q;
    assign first_mask_c = en_mask;
    assign start_ok_c   = |en_mask;

    // Capture the channel mask at the start of a sweep and hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (state_q == IDLE && mode && start && start_ok_c) begin
            mask_q <= en_mask;
        end
    end
`else
    logic unused_en_mask;

    assign scan_mask_c    = '1;
    assign first_mask_c   = '1;
    assign start_ok_c     = 1'b1;
    assign unused_en_mask = ^en_mask;
`endif

    logic              sel_ok_c;
    logic [W-1:0]      sel_data_c;
    logic [W-1:0]      ch_data_c;
    logic [SEL_W-1:0]  first_c;
    logic [SEL_W-1:0]  last_c;
    logic [SEL_W-1:0]  next_c;
    logic              dwell_end_c;

    assign sel_ok_c    = {1'b0, sel} < (SEL_W+1)'(N_CH);
    assign dwell_end_c = (dwell_q == DW_W'(DWELL - 1));

    // Channel data selection and first/last/next enabled channel search.
    always_comb begin
        sel_data_c = '0;
        ch_data_c  = '0;
        first_c    = '0;
        last_c     = '0;
        next_c     = ch_q;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k))   sel_data_c = din[k*W +: W];
            if (ch_q == SEL_W'(k))  ch_data_c  = din[k*W +: W];
            if (scan_mask_c[k])     last_c     = SEL_W'(k);
        end
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (first_mask_c[k])                      first_c = SEL_W'(k);
            if (scan_mask_c[k] && SEL_W'(k) > ch_q)   next_c  = SEL_W'(k);
        end
    end

    // Mode FSM with registered outputs and channel/dwell counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            dwell_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            cur_ch_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ch_q    <= '0;
                    dwell_q <= '0;
                    if (!mode) begin
                        dout_q   <= sel_ok_c ? sel_data_c : '0;
                        valid_q  <= sel_ok_c;
                        cur_ch_q <= sel;
                    end else begin
                        valid_q <= 1'b0;
                        if (start && start_ok_c) begin
                            state_q <= SCAN;
                            ch_q    <= first_c;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        ch_q    <= '0;
                        dwell_q <= '0;
                    end else begin
                        dout_q   <= ch_data_c;
                        cur_ch_q <= ch_q;
                        valid_q  <= dwell_end_c;
                        if (dwell_end_c) begin
                            dwell_q <= '0;
                            if (ch_q == last_c) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                ch_q    <= '0;
                            end else begin
                                ch_q <= next_c;
                            end
                        end else begin
                            dwell_q <= dwell_q + DW_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign cur_ch     = cur_ch_q;
    assign busy       = busy_q;

endmodule
